// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load, hold buffer and shift strobe.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             last_edge;
    logic             load_en;
    logic [WIDTH-1:0] load_w;
    logic [WIDTH-1:0] shifted;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign accept    = load_valid && !hold_full_q;
    assign last_edge = (state_q == SHIFT) && shift_en && (cnt_q == LAST_CNT);
    assign shifted   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        vld_d       = vld_q;
        done_d      = 1'b0;
        load_en     = 1'b0;
        load_w      = din;
`ifdef PISO_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                load_en = accept;
            end
            SHIFT: begin
                if (last_edge) begin
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        load_en     = 1'b1;
                        load_w      = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                        dout_d  = IDLE_LEVEL;
                        vld_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    if (shift_en) begin
                        cnt_d   = cnt_q + CW'(1);
                        shreg_d = shifted;
                        dout_d  = first_bit(shifted);
`ifdef PISO_PARITY_EN
                        // Data exhausted: the trailer carries the word's parity.
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            dout_d = par_q;
                        end
`endif
                    end
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_en) begin
            state_d = SHIFT;
            shreg_d = load_w;
            cnt_d   = '0;
            dout_d  = first_bit(load_w);
            vld_d   = 1'b1;
`ifdef PISO_PARITY_EN
            par_d   = ^load_w;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            dout_q      <= IDLE_LEVEL;
            vld_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign load_ready = !hold_full_q;
    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign busy       = (state_q == SHIFT) || hold_full_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share all inputs.
// Build with PISO_PARITY_EN defined to exercise the parity trailer.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] din;
    logic       shift_en;
    logic       ready_m, ready_l;
    logic       dout_m, dout_l;
    logic       vld_m, vld_l;
    logic       busy_m, busy_l;
    logic       done_m, done_l;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .din        (din),
        .shift_en   (shift_en),
        .dout       (dout_m),
        .dout_valid (vld_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .din        (din),
        .shift_en   (shift_en),
        .dout       (dout_l),
        .dout_valid (vld_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: one entry per serial bit still owed by the DUTs.
    typedef struct {
        logic bm;
        logic bl;
        logic last;
    } sbit_t;

    sbit_t q[$];
    logic  exp_done = 1'b0;
    bit    mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_valid_m", vld_m, q.size() != 0);
            chk("sb_valid_l", vld_l, q.size() != 0);
            if (q.size() != 0) begin
                chk("sb_dout_m", dout_m, q[0].bm);
                chk("sb_dout_l", dout_l, q[0].bl);
            end else begin
                chk("sb_idle_m", dout_m, 1'b0);
                chk("sb_idle_l", dout_l, 1'b0);
            end
            chk("sb_done_m", done_m, exp_done);
            chk("sb_done_l", done_l, exp_done);
            chk("sb_ready", ready_m, q.size() <= NBITS);
            chk("sb_busy", busy_l, q.size() != 0);
            if (reset) begin
                q.delete();
                exp_done = 1'b0;
            end else begin
                exp_done = 1'b0;
                if (shift_en && q.size() != 0) begin
                    exp_done = q[0].last;
                    void'(q.pop_front());
                end
                if (load_valid && ready_m) begin
                    for (int k = 0; k < 8; k++) begin
                        q.push_back('{din[7-k], din[k], (k == NBITS - 1)});
                    end
`ifdef PISO_PARITY_EN
                    q.push_back('{^din, ^din, 1'b1});
`endif
                end
            end
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq_m;
        logic [7:0] seq_l;
        logic       par;
    } vec_t;

    vec_t vec[4];
    int   dn[3];
    int   nd;
    int   acc3;
    int   gaps;
    int   t4;

    initial begin
        vec[0] = '{8'hB3, 8'hB3, 8'hCD, 1'b1};
        vec[1] = '{8'hCC, 8'hCC, 8'h33, 1'b0};
        vec[2] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
        vec[3] = '{8'h01, 8'h01, 8'h80, 1'b1};

        reset      = 1'b1;
        load_valid = 1'b0;
        din        = 8'h00;
        shift_en   = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_ready", ready_m, 1'b1);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_valid", vld_m, 1'b0);
        chk("rst_dout", dout_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        reset = 1'b0;
        tick();

        // Single words from idle, continuous strobe, both bit orders.
        shift_en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            load_valid = 1'b1;
            din        = vec[v].din;
            tick();
            load_valid = 1'b0;
            for (int k = 0; k < NBITS; k++) begin
                @(negedge clk);
                if (k < 8) begin
                    chk("tbl_msb", dout_m, vec[v].seq_m[7-k]);
                    chk("tbl_lsb", dout_l, vec[v].seq_l[7-k]);
                end else begin
                    chk("tbl_par_m", dout_m, vec[v].par);
                    chk("tbl_par_l", dout_l, vec[v].par);
                end
                chk("tbl_nodone", done_m, 1'b0);
            end
            @(negedge clk);
            chk("tbl_done", done_m, 1'b1);
            chk("tbl_end_valid", vld_m, 1'b0);
            chk("tbl_end_dout", dout_m, 1'b0);
            tick();
        end

        // Back-to-back words through the hold buffer.
        load_valid = 1'b1;
        din        = 8'hB3;
        tick();
        din = 8'hCC;
        tick();
        chk("b2b_ready_low", ready_m, 1'b0);
        din  = 8'h5A;
        nd   = 0;
        acc3 = -1;
        gaps = 0;
        dn   = '{-1, -1, -1};
        for (int c = 2; c <= 60 && nd < 3; c++) begin
            if (load_valid && ready_m) acc3 = c;
            tick();
            if (acc3 == c) load_valid = 1'b0;
            if (done_m) begin
                dn[nd] = c;
                nd++;
            end
            if (nd < 3 && !vld_m) gaps++;
        end
        load_valid = 1'b0;
        chk_int("b2b_ndone", nd, 3);
        chk_int("b2b_done0", dn[0], NBITS);
        chk_int("b2b_done_gap", dn[1] - dn[0], NBITS);
        chk_int("b2b_done2", dn[2], 3 * NBITS);
        chk_int("b2b_accept3", acc3, NBITS + 1);
        chk_int("b2b_gaps", gaps, 0);
        tick();

        // One strobe every four cycles.
        shift_en   = 1'b0;
        load_valid = 1'b1;
        din        = 8'hA5;
        tick();
        load_valid = 1'b0;
        t4 = -1;
        for (int c = 1; c <= 4 * NBITS + 8 && t4 < 0; c++) begin
            shift_en = (c % 4 == 0);
            tick();
            if (done_m) t4 = c;
        end
        chk_int("div4_len", t4, 4 * NBITS);
        shift_en = 1'b0;
        tick();

        // Reset in the middle of a word.
        shift_en   = 1'b1;
        load_valid = 1'b1;
        din        = 8'hFF;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy_m, 1'b1);
        reset = 1'b1;
        tick();
        chk("mrst_dout", dout_m, 1'b0);
        chk("mrst_valid", vld_l, 1'b0);
        chk("mrst_busy", busy_m, 1'b0);
        chk("mrst_ready", ready_l, 1'b1);
        chk("mrst_done", done_m, 1'b0);
        reset = 1'b0;
        tick();
        chk("mrst_done2", done_l, 1'b0);
        repeat (NBITS + 2) tick();
        shift_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
